// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage for a small MIPS-like core.
// Decodes the fetched word and registers the control bits, register
// specifiers, extended immediate and PC into the ID/EX boundary.
// Load-use hazards are resolved by inserting a bubble and stalling fetch.
// Squashes, downstream back-pressure and bubble insertion are also handled here.
module id_pipe_stage #(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  pc,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             id_valid,
    output logic             reg_dest,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm_ext,
    output logic [5:0]       funct_code,
    output logic [XLEN-1:0]  pc_out,
    output logic             if_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       reg_dest;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // Field extraction from the incoming word
    logic [5:0]      w_opcode;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [5:0]      w_funct;
    logic [XLEN-1:0] w_imm_ext;
    ctrl_t           w_ctrl;
    logic            w_rt_is_src;
    logic            w_hazard;

    // ID/EX boundary registers
    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [4:0]      r_rs;
    logic [4:0]      r_rt;
    logic [4:0]      r_rd;
    logic [5:0]      r_funct;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [CNT_W-1:0] r_bubble_cnt;

    assign w_opcode  = instruction[31:26];
    assign w_rs      = instruction[25:21];
    assign w_rt      = instruction[20:16];
    assign w_rd      = instruction[15:11];
    assign w_funct   = instruction[5:0];
    assign w_imm_ext = SIGN_EXT ? {{(XLEN-16){instruction[15]}}, instruction[15:0]}
                                : {{(XLEN-16){1'b0}}, instruction[15:0]};

    // Main decoder: opcode to control bits, plus whether rt is read as a source
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_ctrl      = '0;
        w_rt_is_src = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dest  = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = 2'b10;
                w_rt_is_src      = 1'b1;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_rt_is_src      = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = 2'b01;
                w_rt_is_src   = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            default: w_ctrl.illegal = if_valid;
        endcase
    end

    // A load in ID whose destination is read by the incoming instruction.
    // Register $0 is never a real dependency.
    assign w_hazard = r_valid & r_ctrl.mem_read & (r_rt != 5'd0) & if_valid &
                      ((r_rt == w_rs) | ((r_rt == w_rt) & w_rt_is_src));

    assign if_stall = ~flush & (ex_hold | w_hazard);

    // Pipeline register update, priority rst > flush > ex_hold > hazard > load
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_funct <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (ex_hold) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            // Bubble: controls cleared so nothing downstream writes state
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= if_valid;
            r_ctrl  <= if_valid ? w_ctrl : '0;
            r_rs    <= w_rs;
            r_rt    <= w_rt;
            r_rd    <= w_rd;
            r_funct <= w_funct;
            r_imm   <= w_imm_ext;
            r_pc    <= pc;
        end
    end

    // Saturating count of hazard bubbles; flush squashes are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (~flush & ~ex_hold & w_hazard & (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign id_valid   = r_valid;
    assign reg_dest   = r_ctrl.reg_dest;
    assign alu_src    = r_ctrl.alu_src;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign branch     = r_ctrl.branch;
    assign alu_op     = r_ctrl.alu_op;
    assign illegal    = r_ctrl.illegal;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign rd         = r_rd;
    assign imm_ext    = r_imm;
    assign funct_code = r_funct;
    assign pc_out     = r_pc;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: decode, extension, load-use bubbles,
// flush, back-pressure, illegal opcodes and mid-stream reset.
module tb_id_pipe_stage;

    localparam logic [31:0] I_ADD   = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] I_LW8   = 32'h8C28FFFC; // lw  $8,-4($1)
    localparam logic [31:0] I_USE8  = 32'h010A4820; // add $9,$8,$10
    localparam logic [31:0] I_ADDI8 = 32'h20280005; // addi $8,$1,5
    localparam logic [31:0] I_BEQ8  = 32'h10280003; // beq $1,$8,3
    localparam logic [31:0] I_LW0   = 32'h8C200004; // lw  $0,4($1)
    localparam logic [31:0] I_ADD0  = 32'h00004020; // add $8,$0,$0
    localparam logic [31:0] I_ILL   = 32'hFC000000; // opcode 0x3F

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ex_hold;
    logic [31:0] instruction, pc;

    logic        id_valid, reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal, if_stall;
    logic [1:0]  alu_op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext, pc_out;
    logic [5:0]  funct_code;
    logic [15:0] bubble_cnt;

    logic        z_id_valid, z_reg_dest, z_alu_src, z_mem_to_reg, z_reg_write, z_mem_read, z_mem_write, z_branch, z_illegal, z_if_stall;
    logic [1:0]  z_alu_op;
    logic [4:0]  z_rs, z_rt, z_rd;
    logic [31:0] z_imm_ext, z_pc_out;
    logic [5:0]  z_funct_code;
    logic [15:0] z_bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_pipe_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc(pc),
        .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid), .reg_dest(reg_dest),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .alu_op(alu_op), .illegal(illegal),
        .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .funct_code(funct_code),
        .pc_out(pc_out), .if_stall(if_stall), .bubble_cnt(bubble_cnt)
    );

    id_pipe_stage #(.SIGN_EXT(1'b0)) dut_z (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc(pc),
        .flush(flush), .ex_hold(ex_hold), .id_valid(z_id_valid), .reg_dest(z_reg_dest),
        .alu_src(z_alu_src), .mem_to_reg(z_mem_to_reg), .reg_write(z_reg_write), .mem_read(z_mem_read),
        .mem_write(z_mem_write), .branch(z_branch), .alu_op(z_alu_op), .illegal(z_illegal),
        .rs(z_rs), .rt(z_rt), .rd(z_rd), .imm_ext(z_imm_ext), .funct_code(z_funct_code),
        .pc_out(z_pc_out), .if_stall(z_if_stall), .bubble_cnt(z_bubble_cnt)
    );

    // Apply inputs after the edge, settle, then advance one clock
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        if_valid = v; instruction = ins; pc = p; #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0; drive(1'b0, 32'h0, 32'h0);
        tick(); tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset.id_valid got=%0h exp=0", id_valid); end
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset.reg_write got=%0h exp=0", reg_write); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset.pc_out got=%0h exp=0", pc_out); end
        n_checks++; if (bubble_cnt !== 16'h0) begin n_fail++; $display("FAIL reset.bubble_cnt got=%0h exp=0", bubble_cnt); end
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL reset.if_stall got=%0h exp=0", if_stall); end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        drive(1'b1, I_ADD, 32'h40);
        tick();
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rtype.id_valid got=%0h exp=1", id_valid); end
        n_checks++; if ({reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} !== 7'b1001000)
            begin n_fail++; $display("FAIL rtype.ctrl got=%b exp=1001000", {reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}); end
        n_checks++; if (alu_op !== 2'b10) begin n_fail++; $display("FAIL rtype.alu_op got=%b exp=10", alu_op); end
        n_checks++; if ({rs, rt, rd} !== {5'd9, 5'd10, 5'd8}) begin n_fail++; $display("FAIL rtype.regs got=%0d,%0d,%0d exp=9,10,8", rs, rt, rd); end
        n_checks++; if (funct_code !== 6'h20) begin n_fail++; $display("FAIL rtype.funct got=%0h exp=20", funct_code); end
        n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL rtype.pc_out got=%0h exp=40", pc_out); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rtype.illegal got=%0h exp=0", illegal); end
    endtask

    task automatic test_sign_ext();
        drive(1'b1, I_LW8, 32'h44);
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL sext.if_stall got=%0h exp=0", if_stall); end
        tick();
        n_checks++; if (imm_ext !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sext.imm_ext got=%0h exp=fffffffc", imm_ext); end
        n_checks++; if (z_imm_ext !== 32'h0000FFFC) begin n_fail++; $display("FAIL zext.imm_ext got=%0h exp=0000fffc", z_imm_ext); end
        n_checks++; if ({alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op} !== 7'b1111000)
            begin n_fail++; $display("FAIL sext.ctrl got=%b exp=1111000", {alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op}); end
        n_checks++; if (rt !== 5'd8) begin n_fail++; $display("FAIL sext.rt got=%0d exp=8", rt); end
    endtask

    // lw $8 is now in ID
    task automatic test_load_use();
        drive(1'b1, I_USE8, 32'h48);
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL loaduse.if_stall got=%0h exp=1", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse.bubble_valid got=%0h exp=0", id_valid); end
        n_checks++; if ({reg_write, mem_read, mem_to_reg} !== 3'b000) begin n_fail++; $display("FAIL loaduse.bubble_ctrl got=%b exp=000", {reg_write, mem_read, mem_to_reg}); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL loaduse.bubble_cnt got=%0d exp=1", bubble_cnt); end
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL loaduse.stall_release got=%0h exp=0", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || rs !== 5'd8 || rd !== 5'd9 || pc_out !== 32'h48)
            begin n_fail++; $display("FAIL loaduse.replay got=v%0h rs%0d rd%0d pc%0h exp=v1 rs8 rd9 pc48", id_valid, rs, rd, pc_out); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL loaduse.cnt_after got=%0d exp=1", bubble_cnt); end
        // addi writes rt, so a match on rt alone is not a dependency
        drive(1'b1, I_LW8, 32'h4C); tick();
        drive(1'b1, I_ADDI8, 32'h50);
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL addi_rt.if_stall got=%0h exp=0", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || imm_ext !== 32'h5 || alu_src !== 1'b1 || reg_write !== 1'b1)
            begin n_fail++; $display("FAIL addi.decode got=v%0h imm%0h src%0h rw%0h exp=v1 imm5 src1 rw1", id_valid, imm_ext, alu_src, reg_write); end
    endtask

    task automatic test_flush_hazard();
        drive(1'b1, I_LW8, 32'h54); tick();
        flush = 1'b1; drive(1'b1, I_USE8, 32'h58);
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL flush.if_stall got=%0h exp=0", if_stall); end
        tick();
        flush = 1'b0;
        n_checks++; if (id_valid !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL flush.bubble got=v%0h rw%0h exp=v0 rw0", id_valid, reg_write); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL flush.bubble_cnt got=%0d exp=1", bubble_cnt); end
    endtask

    task automatic test_ex_hold();
        drive(1'b1, I_ADD, 32'h60); tick();
        ex_hold = 1'b1; drive(1'b1, I_LW8, 32'h64);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL hold.if_stall cyc%0d got=%0h exp=1", c, if_stall); end
            tick();
            n_checks++; if (id_valid !== 1'b1 || pc_out !== 32'h60 || reg_dest !== 1'b1 || mem_read !== 1'b0 || rd !== 5'd8)
                begin n_fail++; $display("FAIL hold.frozen cyc%0d got=v%0h pc%0h rdst%0h mr%0h rd%0d exp=v1 pc60 rdst1 mr0 rd8", c, id_valid, pc_out, reg_dest, mem_read, rd); end
        end
        ex_hold = 1'b0; #1;
        tick();
        n_checks++; if (pc_out !== 32'h64 || mem_read !== 1'b1) begin n_fail++; $display("FAIL hold.release got=pc%0h mr%0h exp=pc64 mr1", pc_out, mem_read); end
        drive(1'b1, I_ILL, 32'h68); tick();
        n_checks++; if (id_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal.flag got=v%0h ill%0h exp=v1 ill1", id_valid, illegal); end
        n_checks++; if ({reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} !== 9'b0)
            begin n_fail++; $display("FAIL illegal.ctrl got=%b exp=0", {reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, I_LW8, 32'h70); tick();
        ex_hold = 1'b1; rst = 1'b1; #1;
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid.if_stall got=%0h exp=1", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || mem_read !== 1'b0 || pc_out !== 32'h0 || imm_ext !== 32'h0 || rt !== 5'd0)
            begin n_fail++; $display("FAIL rstmid.clear got=v%0h mr%0h pc%0h imm%0h rt%0d exp=all0", id_valid, mem_read, pc_out, imm_ext, rt); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid.bubble_cnt got=%0d exp=0", bubble_cnt); end
        rst = 1'b0; ex_hold = 1'b0; drive(1'b0, I_ADD, 32'h74); tick();
        n_checks++; if (id_valid !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL idle.load got=v%0h rw%0h exp=v0 rw0", id_valid, reg_write); end
        drive(1'b1, I_ADD, 32'h78); tick();
        n_checks++; if (id_valid !== 1'b1 || pc_out !== 32'h78) begin n_fail++; $display("FAIL first_valid got=v%0h pc%0h exp=v1 pc78", id_valid, pc_out); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, I_LW8, 32'h80); tick();
        drive(1'b1, I_BEQ8, 32'h84);
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL beq_rt.if_stall got=%0h exp=1", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b0 || bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_rt.bubble got=v%0h cnt%0d exp=v0 cnt1", id_valid, bubble_cnt); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || branch !== 1'b1 || alu_op !== 2'b01 || reg_write !== 1'b0)
            begin n_fail++; $display("FAIL beq.decode got=v%0h br%0h op%b rw%0h exp=v1 br1 op01 rw0", id_valid, branch, alu_op, reg_write); end
        drive(1'b1, I_LW0, 32'h88); tick();
        drive(1'b1, I_ADD0, 32'h8C);
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL lw_r0.if_stall got=%0h exp=0", if_stall); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || pc_out !== 32'h8C || bubble_cnt !== 16'd1)
            begin n_fail++; $display("FAIL lw_r0.pass got=v%0h pc%0h cnt%0d exp=v1 pc8c cnt1", id_valid, pc_out, bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_sign_ext();
        test_load_use();
        test_flush_hazard();
        test_ex_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
